// File: rtl/tls_interval_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tls_interval_timer
//
// Interval timer for the traffic-light FSM. A prescaler turns clk into timer
// ticks. An elapsed-tick counter then drives a three-state interval FSM:
// SHORT -> LONG -> EXPIRED. The FSM reports the short (ts) and long (tl)
// interval expiries as levels. A restart strobe (st) clears the interval.
// It also loads the active limits from a shadow config register. Config writes
// therefore never disturb an interval that is already running.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset
//   en        in   1      tick enable; 0 freezes prescaler and elapsed count
//   st        in   1      restart strobe, level-sampled every clk
//   cfg_we    in   1      write config shadow register
//   cfg_sel   in   1      0: short limit, 1: long limit
//   cfg_data  in   CNT_W  limit value in ticks
//   ts        out  1      short interval expired (level, registered)
//   tl        out  1      long interval expired (level, registered)
//   elapsed   out  CNT_W  ticks since last restart, saturating
// -----------------------------------------------------------------------------
module tls_interval_timer #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1000,
  parameter int TS_DEF   = 5,
  parameter int TL_DEF   = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             st,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             ts,
  output logic             tl,
  output logic [CNT_W-1:0] elapsed
);

  localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TS_RST  = CNT_W'(TS_DEF);
  localparam logic [CNT_W-1:0] TL_RST  = CNT_W'(TL_DEF);

  localparam logic [1:0] ST_SHORT   = 2'd0;
  localparam logic [1:0] ST_LONG    = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  logic [PRE_W-1:0] pre_q,     pre_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] ts_sh_q,   ts_sh_d;
  logic [CNT_W-1:0] tl_sh_q,   tl_sh_d;
  logic [CNT_W-1:0] ts_lim_q,  ts_lim_d;
  logic [CNT_W-1:0] tl_lim_q,  tl_lim_d;

  logic             tick;
  logic [CNT_W-1:0] ts_eff;
  logic [CNT_W-1:0] tl_base;
  logic [CNT_W-1:0] tl_eff;
  logic [CNT_W:0]   n_next;   // one extra bit so elapsed+1 never wraps at saturation

  // Effective limits: zero means one tick, and tl is never allowed to precede ts.
  always_comb begin
    ts_eff  = (ts_lim_q == '0) ? CNT_ONE : ts_lim_q;
    tl_base = (tl_lim_q == '0) ? CNT_ONE : tl_lim_q;
    tl_eff  = (tl_base < ts_eff) ? ts_eff : tl_base;
  end

  assign tick   = en && (pre_q == PRE_MAX);
  assign n_next = {1'b0, elapsed_q} + (CNT_W+1)'(1);

  always_comb begin
    // NOTE: every variable gets a hold value first, so no path leaves one unassigned and no latch is inferred.
    pre_d     = pre_q;
    elapsed_d = elapsed_q;
    state_d   = state_q;
    ts_sh_d   = ts_sh_q;
    tl_sh_d   = tl_sh_q;
    ts_lim_d  = ts_lim_q;
    tl_lim_d  = tl_lim_q;

    if (cfg_we) begin
      if (cfg_sel) tl_sh_d = cfg_data;
      else         ts_sh_d = cfg_data;
    end

    if (st) begin
      // Load from the post-write shadow so a write on the restart edge takes effect immediately.
      pre_d     = '0;
      elapsed_d = '0;
      state_d   = ST_SHORT;
      ts_lim_d  = ts_sh_d;
      tl_lim_d  = tl_sh_d;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        elapsed_d = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + 1'b1;
        case (state_q)
          ST_SHORT: begin
            if      (n_next >= {1'b0, tl_eff}) state_d = ST_EXPIRED;
            else if (n_next >= {1'b0, ts_eff}) state_d = ST_LONG;
          end
          ST_LONG: begin
            if (n_next >= {1'b0, tl_eff}) state_d = ST_EXPIRED;
          end
          ST_EXPIRED: state_d = ST_EXPIRED;
          default:    state_d = ST_SHORT;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      elapsed_q <= '0;
      state_q   <= ST_SHORT;
      ts_sh_q   <= TS_RST;
      tl_sh_q   <= TL_RST;
      ts_lim_q  <= TS_RST;
      tl_lim_q  <= TL_RST;
    end else begin
      pre_q     <= pre_d;
      elapsed_q <= elapsed_d;
      state_q   <= state_d;
      ts_sh_q   <= ts_sh_d;
      tl_sh_q   <= tl_sh_d;
      ts_lim_q  <= ts_lim_d;
      tl_lim_q  <= tl_lim_d;
    end
  end

  // Outputs decode the state flop directly, so no input has a combinational path to them.
  assign ts      = (state_q == ST_LONG) || (state_q == ST_EXPIRED);
  assign tl      = (state_q == ST_EXPIRED);
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_tls_interval_timer.sv
`timescale 1ns/1ps
module tb_tls_interval_timer;

  logic        clk = 1'b0;
  logic        rst, en, st, cfg_we, cfg_sel;
  logic [15:0] cfg_data;
  logic        ts, tl;
  logic [15:0] elapsed;
  logic        sat_ts, sat_tl;
  logic [3:0]  sat_elapsed;

  always #5 clk = ~clk;

  tls_interval_timer #(.CNT_W(16), .PRESCALE(4), .TS_DEF(2), .TL_DEF(5)) dut (
    .clk(clk), .rst(rst), .en(en), .st(st), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .ts(ts), .tl(tl), .elapsed(elapsed)
  );

  // Narrow, unprescaled copy so elapsed saturation is reachable quickly.
  tls_interval_timer #(.CNT_W(4), .PRESCALE(1), .TS_DEF(2), .TL_DEF(5)) u_sat (
    .clk(clk), .rst(rst), .en(en), .st(st), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data[3:0]), .ts(sat_ts), .tl(sat_tl), .elapsed(sat_elapsed)
  );

  typedef struct {
    string       name;
    logic        pre_we;
    logic        pre_sel;
    logic [15:0] pre_data;
    logic        st_we;
    logic        st_sel;
    logic [15:0] st_data;
    int          exp_ts;
    int          exp_tl;
    int          exp_el;
  } vec_t;

  typedef struct {
    string name;
    int    ts_at;
    int    tl_at;
    int    el;
  } exp_t;

  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input logic sel, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    step(1);
    cfg_we   = 1'b0;
  endtask

  // Pulse st (optionally with a config write on the same edge), then count
  // edges until ts and tl rise. Expectations go into the scoreboard at the
  // restart and are popped once tl is seen or the cycle budget runs out.
  task automatic run_interval(input string name,
                              input logic st_we, input logic st_sel, input logic [15:0] st_data,
                              input int exp_ts, input int exp_tl, input int exp_el,
                              input int mid_k, input logic mid_sel, input logic [15:0] mid_data,
                              input int en_lo_k, input int en_lo_len);
    exp_t e;
    int   ts_at, tl_at, el_at;
    e.name = name; e.ts_at = exp_ts; e.tl_at = exp_tl; e.el = exp_el;
    sb_q.push_back(e);
    st       = 1'b1;
    cfg_we   = st_we;
    cfg_sel  = st_sel;
    cfg_data = st_data;
    step(1);
    st     = 1'b0;
    cfg_we = 1'b0;
    check({name, "_restart_ts"}, ts, 0);
    check({name, "_restart_tl"}, tl, 0);
    check({name, "_restart_elapsed"}, elapsed, 0);
    ts_at = -1; tl_at = -1; el_at = -1;
    for (int k = 1; k <= 200 && tl_at < 0; k++) begin
      en       = !(k >= en_lo_k && k < en_lo_k + en_lo_len);
      cfg_we   = (k == mid_k);
      cfg_sel  = mid_sel;
      cfg_data = mid_data;
      step(1);
      if (ts === 1'b1 && ts_at < 0) ts_at = k;
      if (tl === 1'b1 && tl_at < 0) begin
        tl_at = k;
        el_at = int'(elapsed);
      end
    end
    en     = 1'b1;
    cfg_we = 1'b0;
    e = sb_q.pop_front();
    check({e.name, "_ts_edge"}, ts_at, e.ts_at);
    check({e.name, "_tl_edge"}, tl_at, e.tl_at);
    check({e.name, "_elapsed_at_tl"}, el_at, e.el);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"default",      1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0,  8, 20, 5};
    vecs[1] = '{"shadow_ts3",   1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 16'd0, 12, 20, 5};
    vecs[2] = '{"same_edge_tl1",1'b1, 1'b0, 16'd2, 1'b1, 1'b1, 16'd1,  8,  8, 2};
    vecs[3] = '{"ts_zero",      1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0,  4,  4, 1};
    vecs[4] = '{"tl_zero_ts6",  1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 16'd6, 24, 24, 6};
    vecs[5] = '{"ts1_tl3",      1'b1, 1'b0, 16'd1, 1'b1, 1'b1, 16'd3,  4, 12, 3};

    rst = 1'b1; en = 1'b1; st = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
    @(negedge clk);
    step(3);
    check("reset_ts", ts, 0);
    check("reset_tl", tl, 0);
    check("reset_elapsed", elapsed, 0);
    rst = 1'b0;

    // Baseline interval, then let the narrow copy run past its counter range.
    run_interval("base", 1'b0, 1'b0, 16'd0, 8, 20, 5, -1, 1'b0, 16'd0, -1, 0);
    step(10);
    check("main_elapsed_30", elapsed, 7);
    check("sat_elapsed", sat_elapsed, 15);
    check("sat_ts", sat_ts, 1);
    check("sat_tl", sat_tl, 1);

    foreach (vecs[i]) begin
      if (vecs[i].pre_we) cfg_write(vecs[i].pre_sel, vecs[i].pre_data);
      run_interval(vecs[i].name, vecs[i].st_we, vecs[i].st_sel, vecs[i].st_data,
                   vecs[i].exp_ts, vecs[i].exp_tl, vecs[i].exp_el, -1, 1'b0, 16'd0, -1, 0);
    end

    // Mid-interval write only reaches the shadow; it shows after the next restart.
    cfg_write(1'b0, 16'd2);
    cfg_write(1'b1, 16'd5);
    run_interval("mid_cfg", 1'b0, 1'b0, 16'd0, 8, 20, 5, 3, 1'b0, 16'd3, -1, 0);
    run_interval("after_mid", 1'b0, 1'b0, 16'd0, 12, 20, 5, -1, 1'b0, 16'd0, -1, 0);

    // Ten cycles of en=0 starting at E+3 delay everything by ten edges.
    cfg_write(1'b0, 16'd2);
    run_interval("en_pause", 1'b0, 1'b0, 16'd0, 18, 30, 5, -1, 1'b0, 16'd0, 3, 10);

    // In LONG, en=0 freezes everything; then a restart drops ts/tl at once.
    st = 1'b1;
    step(1);
    st = 1'b0;
    step(10);
    check("long_ts", ts, 1);
    check("long_tl", tl, 0);
    check("long_elapsed", elapsed, 2);
    en = 1'b0;
    step(30);
    check("frozen_ts", ts, 1);
    check("frozen_tl", tl, 0);
    check("frozen_elapsed", elapsed, 2);
    en = 1'b1;
    run_interval("restart_long", 1'b0, 1'b0, 16'd0, 8, 20, 5, -1, 1'b0, 16'd0, -1, 0);

    // st held high keeps the block in restart.
    st = 1'b1;
    step(10);
    check("st_hold_elapsed", elapsed, 0);
    check("st_hold_ts", ts, 0);
    check("st_hold_tl", tl, 0);
    run_interval("after_hold", 1'b0, 1'b0, 16'd0, 8, 20, 5, -1, 1'b0, 16'd0, -1, 0);

    // Reset in EXPIRED with shadow at 7 returns limits to the defaults.
    cfg_write(1'b0, 16'd7);
    cfg_write(1'b1, 16'd7);
    check("pre_rst_tl", tl, 1);
    rst = 1'b1;
    step(1);
    check("rst_exp_ts", ts, 0);
    check("rst_exp_tl", tl, 0);
    check("rst_exp_elapsed", elapsed, 0);
    rst = 1'b0;
    run_interval("post_rst", 1'b0, 1'b0, 16'd0, 8, 20, 5, -1, 1'b0, 16'd0, -1, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
